// File: rtl/word16_out_fifo_pkg.sv
// Shared definitions for the word16 output FIFO slice.
//   DEF_DATA_W : default word width
//   DEF_DEPTH  : default FIFO depth (power of two, >= 2)
//   DROP_W     : width of the saturating drop counter
//   DROP_MAX   : saturation value of the drop counter
//   is_pow2()  : elaboration-time depth sanity helper
package word16_out_fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 4;
  localparam int DROP_W     = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/word16_out_fifo_if.sv
// Bus bundle between the converter/downstream side and the output FIFO.
//   valid_in, data_in : converter words, valid-only (no backpressure)
//   ready_in          : downstream acceptance
//   valid_out,data_out: head-of-FIFO word (first-word-fall-through)
//   level             : occupancy 0..DEPTH
//   overflow          : sticky drop flag
//   drop_cnt          : saturating count of dropped words
// master = environment side driving the inputs, slave = the FIFO.
interface word16_out_fifo_if
  import word16_out_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  logic                    valid_in;
  logic [DATA_W-1:0]       data_in;
  logic                    ready_in;
  logic                    valid_out;
  logic [DATA_W-1:0]       data_out;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;
  logic [DROP_W-1:0]       drop_cnt;

  modport master (
    output valid_in,
    output data_in,
    output ready_in,
    input  valid_out,
    input  data_out,
    input  level,
    input  overflow,
    input  drop_cnt
  );

  modport slave (
    input  valid_in,
    input  data_in,
    input  ready_in,
    output valid_out,
    output data_out,
    output level,
    output overflow,
    output drop_cnt
  );

endinterface

// File: rtl/word16_fifo_mem.sv
// Storage array for the output FIFO.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data
// The array has no reset; the top gates data_out to 0 while empty, so
// stale contents are never visible.
module word16_fifo_mem
  import word16_out_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/word16_out_fifo.sv
// Elastic buffer behind the 8-to-16 width converter.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   fifo_bus : slave side of word16_out_fifo_if
// Words arrive valid-only; when full with no pop the word is dropped,
// overflow is set sticky and drop_cnt counts (saturating).
// Pointers carry one extra MSB so full and empty are distinguishable.
module word16_out_fifo
  import word16_out_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  word16_out_fifo_if.slave fifo_bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("word16_out_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [DATA_W-1:0] rdata;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // A pop frees the head slot in the same edge, so a full FIFO can still
  // take the incoming word when downstream is accepting.
  assign pop  = !empty && fifo_bus.ready_in;
  assign push = fifo_bus.valid_in && (!full || pop);
  assign drop = fifo_bus.valid_in && full && !pop;

  word16_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (fifo_bus.data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  // Gating on empty keeps data_out at 0 after reset without clearing the array.
  assign fifo_bus.valid_out = !empty;
  assign fifo_bus.data_out  = empty ? '0 : rdata;
  assign fifo_bus.level     = wr_ptr - rd_ptr;
  assign fifo_bus.overflow  = overflow_q;
  assign fifo_bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_word16_out_fifo.sv
module tb_word16_out_fifo;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  word16_out_fifo_if #(.DATA_W(16), .DEPTH(DEPTH)) bus ();

  word16_out_fifo #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fifo_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] sb [$];
  logic        m_ovf;
  logic [7:0]  m_drop;

  typedef struct {
    logic        vi;
    logic [15:0] di;
    logic        ri;
    logic        e_vo;
    logic [15:0] e_do;
    logic [2:0]  e_lvl;
    logic        e_ovf;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, compare pre-edge outputs against the
  // scoreboard, then advance the model for the coming edge.
  task automatic step(input logic vi, input logic [15:0] di, input logic ri);
    int          sz;
    bit          popped;
    logic [15:0] exp_d;
    @(negedge clk);
    bus.valid_in = vi;
    bus.data_in  = di;
    bus.ready_in = ri;
    #1;
    sz = sb.size();
    check("valid_out", {31'd0, bus.valid_out}, {31'd0, (sz != 0)});
    check("level", {29'd0, bus.level}, sz);
    check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
    check("drop_cnt", {24'd0, bus.drop_cnt}, {24'd0, m_drop});
    popped = 1'b0;
    if (sz != 0) begin
      exp_d = sb[0];
      check("data_out", {16'd0, bus.data_out}, {16'd0, exp_d});
      if (ri) begin
        void'(sb.pop_front());
        popped = 1'b1;
      end
    end
    if (vi) begin
      if (sz < DEPTH || popped) begin
        sb.push_back(di);
      end else begin
        m_ovf = 1'b1;
        if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
      end
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_ovf  = 1'b0;
    m_drop = 8'd0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 16'h0;
    bus.ready_in = 1'b0;
    rst_n = 1'b0;
    model_clear();
    #12;
    check("reset_valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("reset_data_out", {16'd0, bus.data_out}, 32'd0);
    check("reset_level", {29'd0, bus.level}, 32'd0);
    check("reset_overflow", {31'd0, bus.overflow}, 32'd0);
    check("reset_drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // vi, di, ri | valid_out, data_out, level, overflow, drop_cnt seen this cycle
    tbl[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 3'd1, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 16'hA001, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 16'hA002, 1'b0, 1'b1, 16'hA001, 3'd1, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 16'hA003, 1'b0, 1'b1, 16'hA001, 3'd2, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 16'hA004, 1'b0, 1'b1, 16'hA001, 3'd3, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 16'hA005, 1'b0, 1'b1, 16'hA001, 3'd4, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 16'hB000, 1'b1, 1'b1, 16'hA001, 3'd4, 1'b1, 8'd1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA002, 3'd4, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA003, 3'd3, 1'b1, 8'd1};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA004, 3'd2, 1'b1, 8'd1};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hB000, 3'd1, 1'b1, 8'd1};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 8'd1};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].vi, tbl[i].di, tbl[i].ri);
      check($sformatf("tbl%0d_valid_out", i), {31'd0, bus.valid_out}, {31'd0, tbl[i].e_vo});
      if (tbl[i].e_vo) begin
        check($sformatf("tbl%0d_data_out", i), {16'd0, bus.data_out}, {16'd0, tbl[i].e_do});
      end
      check($sformatf("tbl%0d_level", i), {29'd0, bus.level}, {29'd0, tbl[i].e_lvl});
      check($sformatf("tbl%0d_overflow", i), {31'd0, bus.overflow}, {31'd0, tbl[i].e_ovf});
      check($sformatf("tbl%0d_drop_cnt", i), {24'd0, bus.drop_cnt}, {24'd0, tbl[i].e_drop});
    end

    // Streaming: push and pop every cycle, pointers wrap several times.
    hard_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'(i), 1'b1);
      check("stream_level_le1", {31'd0, (bus.level <= 3'd1)}, 32'd1);
      if (i > 0) check("stream_data", {16'd0, bus.data_out}, i - 1);
    end
    step(1'b0, 16'h0, 1'b1);
    check("stream_last", {16'd0, bus.data_out}, 32'h13);
    step(1'b0, 16'h0, 1'b0);

    // Drop counter saturation.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 16'hD000 + 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("sat_drop_cnt", {24'd0, bus.drop_cnt}, 32'd255);
    check("sat_overflow", {31'd0, bus.overflow}, 32'd1);

    // Asynchronous reset mid-stream with level 3.
    step(1'b0, 16'h0, 1'b1);
    @(negedge clk);
    bus.ready_in = 1'b0;
    #1;
    check("pre_reset_level", {29'd0, bus.level}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("async_rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("async_rst_level", {29'd0, bus.level}, 32'd0);
    check("async_rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("async_rst_drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);
    check("async_rst_data_out", {16'd0, bus.data_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, valid_in possible every cycle, mixed ready.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 8)));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 16'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
